// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared types and defaults for the two-master memory arbiter
package mem_arbiter_pkg;

  // Arbiter transaction phases: waiting for a request, waiting on the bus, answering the owner.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Default number of BUSY cycles tolerated without mem_ready before aborting.
  localparam int unsigned TIMEOUT_DEFAULT = 1023;

endpackage

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin arbiter sharing one memory bus between two masters
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,

  input  logic        m0_valid,
  input  logic        m0_instr,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wstrb,
  output logic [31:0] m0_rdata,
  output logic        m0_ready,

  input  logic        m1_valid,
  input  logic        m1_instr,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wstrb,
  output logic [31:0] m1_rdata,
  output logic        m1_ready,

  output logic        mem_valid,
  output logic        mem_instr,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,

  output logic        timeout_err
);

  state_t      state_q, state_d;
  logic        last_grant_q;
  logic        owner_q;
  logic        instr_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  wstrb_q;
  logic [31:0] cnt_q;
  logic        abort_q;
  logic [31:0] rdata_q;

  logic        grant_valid;
  logic        grant_sel;
  logic        timed_out;

  // Pick a requester: a lone valid wins outright, a tie goes to whoever was not granted last.
  always_comb begin
    grant_valid = m0_valid | m1_valid;
    grant_sel   = (m0_valid && m1_valid) ? ~last_grant_q : m1_valid;
    timed_out   = (cnt_q == 32'(TIMEOUT));
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: RESP always lasts exactly one cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (grant_valid) state_d = ST_BUSY;
      ST_BUSY: if (mem_ready || timed_out) state_d = ST_RESP;
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath: latch the granted request, count wait cycles, capture the response or abort.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      instr_q      <= 1'b0;
      addr_q       <= 32'd0;
      wdata_q      <= 32'd0;
      wstrb_q      <= 4'd0;
      cnt_q        <= 32'd0;
      abort_q      <= 1'b0;
      rdata_q      <= 32'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (grant_valid) begin
            owner_q      <= grant_sel;
            last_grant_q <= grant_sel;
            instr_q      <= grant_sel ? m1_instr : m0_instr;
            addr_q       <= grant_sel ? m1_addr  : m0_addr;
            wdata_q      <= grant_sel ? m1_wdata : m0_wdata;
            wstrb_q      <= grant_sel ? m1_wstrb : m0_wstrb;
            cnt_q        <= 32'd0;
            abort_q      <= 1'b0;
          end
        end
        ST_BUSY: begin
          if (mem_ready) begin
            rdata_q <= mem_rdata;
            abort_q <= 1'b0;
          end else if (timed_out) begin
            rdata_q <= 32'd0;
            abort_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 32'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Outputs decode only registered state, so no input reaches an output combinationally.
  always_comb begin
    mem_valid   = 1'b0;
    mem_instr   = 1'b0;
    mem_addr    = 32'd0;
    mem_wdata   = 32'd0;
    mem_wstrb   = 4'd0;
    m0_ready    = 1'b0;
    m0_rdata    = 32'd0;
    m1_ready    = 1'b0;
    m1_rdata    = 32'd0;
    timeout_err = 1'b0;
    case (state_q)
      ST_BUSY: begin
        // The counter is still zero only in the first BUSY cycle.
        mem_valid = (cnt_q == 32'd0);
        mem_instr = instr_q;
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        mem_wstrb = wstrb_q;
      end
      ST_RESP: begin
        if (owner_q) begin
          m1_ready = 1'b1;
          m1_rdata = rdata_q;
        end else begin
          m0_ready = 1'b1;
          m0_rdata = rdata_q;
        end
        timeout_err = abort_q;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter
module tb_mem_arbiter;

  localparam int unsigned TB_TIMEOUT = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_valid, m0_instr, m0_ready;
  logic [31:0] m0_addr, m0_wdata, m0_rdata;
  logic [3:0]  m0_wstrb;
  logic        m1_valid, m1_instr, m1_ready;
  logic [31:0] m1_addr, m1_wdata, m1_rdata;
  logic [3:0]  m1_wstrb;
  logic        mem_valid, mem_instr, mem_ready;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;
  logic        timeout_err;

  int checks = 0;
  int errors = 0;

  // Requester-side view: what each master is currently presenting.
  logic        p_valid [2];
  logic        p_instr [2];
  logic [31:0] p_addr  [2];
  logic [31:0] p_wdata [2];
  logic [3:0]  p_wstrb [2];
  int          last_m;

  always #5 clk = ~clk;

  mem_arbiter #(.TIMEOUT(TB_TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .m0_valid(m0_valid), .m0_instr(m0_instr), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_wstrb(m0_wstrb), .m0_rdata(m0_rdata), .m0_ready(m0_ready),
    .m1_valid(m1_valid), .m1_instr(m1_instr), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_wstrb(m1_wstrb), .m1_rdata(m1_rdata), .m1_ready(m1_ready),
    .mem_valid(mem_valid), .mem_instr(mem_instr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .timeout_err(timeout_err)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic drive_pins();
    m0_valid = p_valid[0]; m0_instr = p_instr[0]; m0_addr = p_addr[0];
    m0_wdata = p_wdata[0]; m0_wstrb = p_wstrb[0];
    m1_valid = p_valid[1]; m1_instr = p_instr[1]; m1_addr = p_addr[1];
    m1_wdata = p_wdata[1]; m1_wstrb = p_wstrb[1];
  endtask

  task automatic new_req(input int m, input logic [31:0] a, input logic [31:0] wd,
                         input logic [3:0] ws, input logic ins);
    p_valid[m] = 1'b1; p_addr[m] = a; p_wdata[m] = wd; p_wstrb[m] = ws; p_instr[m] = ins;
  endtask

  function automatic logic outs_zero();
    return ~|{m0_ready, m1_ready, timeout_err, mem_valid, mem_instr,
              m0_rdata, m1_rdata, mem_addr, mem_wdata, mem_wstrb};
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    for (int m = 0; m < 2; m++) p_valid[m] = 1'b0;
    drive_pins();
    mem_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    last_m = 1;
  endtask

  // One transaction from the IDLE cycle in which requests are presented to the owner's
  // ready cycle. d = cycles after mem_valid at which mem_ready is raised; d > TIMEOUT
  // means the bus never answers in time. join_cyc raises the other master mid-flight.
  task automatic run_txn(input int d, input logic [31:0] rd, input int join_cyc,
                         output int owner_seen);
    int          w;
    bit          aborted;
    int          resp_cyc;
    logic [31:0] exp_data;
    logic        ei;
    logic [31:0] ea, ewd;
    logic [3:0]  ews;
    logic        o_rdy, n_rdy;
    logic [31:0] o_rd, n_rd;
    owner_seen = -1;
    @(negedge clk);
    drive_pins();
    mem_ready = 1'b0;
    if (!p_valid[0] && !p_valid[1]) begin
      errors++;
      $display("FAIL run_txn: no requester valid");
      return;
    end
    w = (p_valid[0] && p_valid[1]) ? ((last_m == 1) ? 0 : 1) : (p_valid[0] ? 0 : 1);
    last_m   = w;
    aborted  = (d > int'(TB_TIMEOUT));
    resp_cyc = aborted ? int'(TB_TIMEOUT) + 2 : d + 2;
    exp_data = aborted ? 32'd0 : rd;
    ei = p_instr[w]; ea = p_addr[w]; ewd = p_wdata[w]; ews = p_wstrb[w];
    @(posedge clk);
    for (int c = 1; c <= resp_cyc; c++) begin
      @(negedge clk);
      if (c < resp_cyc) begin
        checks++;
        if ({mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb} !==
            {(c == 1), ei, ea, ewd, ews}) begin
          errors++;
          $display("FAIL busy_bus cycle %0d: got v=%b i=%b a=%h wd=%h ws=%h expected v=%b i=%b a=%h wd=%h ws=%h",
                   c, mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb, (c == 1), ei, ea, ewd, ews);
        end
        checks++;
        if ({m0_ready, m1_ready, timeout_err, m0_rdata, m1_rdata} !== 67'd0) begin
          errors++;
          $display("FAIL busy_quiet cycle %0d: got r0=%b r1=%b te=%b d0=%h d1=%h expected all 0",
                   c, m0_ready, m1_ready, timeout_err, m0_rdata, m1_rdata);
        end
      end else begin
        owner_seen = m0_ready ? 0 : (m1_ready ? 1 : -1);
        o_rdy = (w == 0) ? m0_ready : m1_ready;
        o_rd  = (w == 0) ? m0_rdata : m1_rdata;
        n_rdy = (w == 0) ? m1_ready : m0_ready;
        n_rd  = (w == 0) ? m1_rdata : m0_rdata;
        checks++;
        if ({o_rdy, o_rd, timeout_err} !== {1'b1, exp_data, aborted}) begin
          errors++;
          $display("FAIL resp_owner m%0d: got ready=%b rdata=%h terr=%b expected ready=1 rdata=%h terr=%b",
                   w, o_rdy, o_rd, timeout_err, exp_data, aborted);
        end
        checks++;
        if ({n_rdy, n_rd} !== 33'd0) begin
          errors++;
          $display("FAIL resp_other m%0d: got ready=%b rdata=%h expected 0", 1 - w, n_rdy, n_rd);
        end
        checks++;
        if ({mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb} !== 70'd0) begin
          errors++;
          $display("FAIL resp_bus: got v=%b a=%h expected all 0", mem_valid, mem_addr);
        end
      end
      mem_ready = (c == d + 1);
      mem_rdata = (c == d + 1) ? rd : $urandom;
      if (c == join_cyc) begin
        p_valid[1 - w] = 1'b1;
        drive_pins();
      end
      if (c == resp_cyc) begin
        p_valid[w] = 1'b0;
        drive_pins();
      end
    end
  endtask

  task automatic test_reset();
    int dummy;
    rst = 1'b1;
    for (int m = 0; m < 2; m++) begin
      p_valid[m] = 1'b0; p_instr[m] = 1'b0; p_addr[m] = '0; p_wdata[m] = '0; p_wstrb[m] = '0;
    end
    drive_pins();
    mem_ready = 1'b1;
    mem_rdata = 32'hA5A5_A5A5;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (outs_zero() !== 1'b1) begin
      errors++;
      $display("FAIL reset_outputs: got nonzero outputs expected all 0");
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (outs_zero() !== 1'b1) begin
      errors++;
      $display("FAIL post_reset_outputs: got nonzero outputs expected all 0");
    end
    mem_ready = 1'b0;
    last_m = 1;
    dummy = 0;
  endtask

  task automatic test_read_latency();
    int own;
    new_req(0, 32'h100, 32'h0, 4'h0, 1'b0);
    run_txn(2, 32'hDEADBEEF, 0, own);
    checks++;
    if (own !== 0) begin
      errors++;
      $display("FAIL read_owner: got %0d expected 0", own);
    end
  endtask

  task automatic test_tie_rr();
    int own;
    int exp_order [4] = '{0, 1, 0, 1};
    do_reset();
    new_req(0, 32'h0000_0040, 32'h1, 4'h0, 1'b1);
    new_req(1, 32'h0000_0080, 32'h2, 4'h0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      run_txn(1, $urandom, 0, own);
      checks++;
      if (own !== exp_order[i]) begin
        errors++;
        $display("FAIL tie_order[%0d]: got m%0d expected m%0d", i, own, exp_order[i]);
      end
      new_req(own == 0 ? 0 : 1, $urandom, $urandom, 4'h3, 1'b0);
    end
    for (int m = 0; m < 2; m++) p_valid[m] = 1'b0;
  endtask

  task automatic test_write();
    int own;
    new_req(1, 32'h2000, 32'h1234_5678, 4'hF, 1'b0);
    run_txn(0, $urandom, 0, own);
    checks++;
    if (own !== 1) begin
      errors++;
      $display("FAIL write_owner: got %0d expected 1", own);
    end
  endtask

  task automatic test_timeout();
    int own;
    new_req(0, 32'h300, 32'h0, 4'h0, 1'b0);
    run_txn(1000, 32'hFFFF_FFFF, 0, own);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (outs_zero() !== 1'b1) begin
        errors++;
        $display("FAIL late_ready_ignored cycle %0d: got r0=%b r1=%b mv=%b expected all 0",
                 i, m0_ready, m1_ready, mem_valid);
      end
      mem_ready = (i < 2);
      mem_rdata = $urandom;
    end
    mem_ready = 1'b0;
  endtask

  task automatic test_timeout_boundary();
    int own;
    new_req(1, 32'h400, 32'h0, 4'h0, 1'b1);
    run_txn(int'(TB_TIMEOUT), 32'hCAFE_0001, 0, own);
    new_req(1, 32'h404, 32'h0, 4'h0, 1'b1);
    run_txn(int'(TB_TIMEOUT) + 1, 32'hCAFE_0002, 0, own);
  endtask

  task automatic test_reset_mid();
    int own;
    new_req(0, 32'h500, 32'h0, 4'h0, 1'b0);
    @(negedge clk);
    drive_pins();
    mem_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (mem_valid !== 1'b1) begin
      errors++;
      $display("FAIL midreset_first_busy: got mem_valid=%b expected 1", mem_valid);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (outs_zero() !== 1'b1) begin
      errors++;
      $display("FAIL midreset_outputs: got r0=%b mv=%b addr=%h expected all 0", m0_ready, mem_valid, mem_addr);
    end
    rst = 1'b0;
    p_valid[0] = 1'b0;
    drive_pins();
    mem_ready = 1'b1;
    mem_rdata = 32'h0BAD_0BAD;
    @(negedge clk);
    checks++;
    if (outs_zero() !== 1'b1) begin
      errors++;
      $display("FAIL midreset_no_ready: got r0=%b d0=%h expected all 0", m0_ready, m0_rdata);
    end
    mem_ready = 1'b0;
    last_m = 1;
    new_req(0, 32'h504, 32'h0, 4'h0, 1'b0);
    run_txn(3, 32'h600D_600D, 0, own);
  endtask

  task automatic test_reassert_rr();
    int own;
    do_reset();
    new_req(1, 32'h700, 32'hAAAA_5555, 4'h5, 1'b0);
    p_valid[1] = 1'b0;
    new_req(0, 32'h600, 32'h0, 4'h0, 1'b0);
    run_txn(2, $urandom, 2, own);
    new_req(0, 32'h608, 32'h0, 4'h0, 1'b1);
    run_txn(1, $urandom, 0, own);
    checks++;
    if (own !== 1) begin
      errors++;
      $display("FAIL reassert_rr: got m%0d expected m1", own);
    end
    run_txn(0, $urandom, 0, own);
    checks++;
    if (own !== 0) begin
      errors++;
      $display("FAIL reassert_next: got m%0d expected m0", own);
    end
  endtask

  task automatic test_random();
    int own;
    int d;
    for (int i = 0; i < 40; i++) begin
      for (int m = 0; m < 2; m++) begin
        if (!p_valid[m] && ($urandom_range(0, 1) == 1))
          new_req(m, $urandom, $urandom, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
      end
      if (!p_valid[0] && !p_valid[1])
        new_req($urandom_range(0, 1), $urandom, $urandom, 4'h0, 1'b0);
      if ($urandom_range(0, 3) == 0) d = int'(TB_TIMEOUT) + $urandom_range(0, 1);
      else d = $urandom_range(0, 4);
      run_txn(d, $urandom, 0, own);
    end
    for (int m = 0; m < 2; m++) p_valid[m] = 1'b0;
    drive_pins();
  endtask

  initial begin
    test_reset();
    test_read_latency();
    test_tie_rr();
    test_write();
    test_timeout();
    test_timeout_boundary();
    test_reset_mid();
    test_reassert_rr();
    test_random();
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
